// File: rtl/char_scan.sv
// char_scan: raster-order reader of the character buffer, emitting a tagged valid/ready char stream.
// Latency: a read issued in cycle N is captured at the end of cycle N+1; first ch_valid 2 cycles after start.
// Backpressure: credit-limited to a 2-entry FWFT skid FIFO; reads stall and the address holds while it is full.
// Optional feature macro CHAR_SCAN_LINE_REPEAT_EN: each row is scanned 8 times (font scanlines), adds ch_line.
module char_scan #(
   parameter int COLS       = 160,
   parameter int ROWS       = 64,
   parameter int FIFO_DEPTH = 2
) (
   input  logic       r_clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       frame_done,
   output logic [7:0] r_row,
   output logic [7:0] r_col,
   input  logic [7:0] a_out,
   output logic [7:0] ch_data,
   output logic [7:0] ch_row,
   output logic [7:0] ch_col,
   output logic       ch_eol,
   output logic       ch_eof,
   output logic       ch_valid,
`ifdef CHAR_SCAN_LINE_REPEAT_EN
   output logic [2:0] ch_line,
`endif
   input  logic       ch_ready
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] row;
      logic [7:0] col;
      logic       eol;
      logic       eof;
`ifdef CHAR_SCAN_LINE_REPEAT_EN
      logic [2:0] line;
`endif
   } ent_t;

   state_t     state, state_nxt;
   ent_t       slot0, slot1;
   ent_t       tag_q, issue_ent, push_ent;
   logic [1:0] count;
   logic [1:0] occ;
   logic       inflight;
   logic       issue;
   logic       push, pop;
   logic       at_eol, at_last, line_last;

`ifdef CHAR_SCAN_LINE_REPEAT_EN
   logic [2:0] line_q;
   assign line_last = (line_q == 3'd7);
`else
   assign line_last = 1'b1;
`endif

   assign at_eol  = (r_col == 8'(COLS - 1));
   assign at_last = at_eol && (r_row == 8'(ROWS - 1)) && line_last;

   assign push = inflight;
   assign pop  = ch_valid && ch_ready;
   // count is at most 2 and pop implies count >= 1, so this never wraps
   assign occ  = count + {1'b0, inflight} - {1'b0, pop};

   // state register
   always_ff @(posedge r_clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SCAN;
         SCAN:    if (issue && at_last) state_nxt = DRAIN;
         DRAIN:   if ((count == 2'd0) && !inflight) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: status and the read-issue decision (credit check includes a same-cycle pop)
   always_comb begin
      busy       = (state != IDLE);
      frame_done = (state == DRAIN) && (count == 2'd0) && !inflight;
      issue      = (state == SCAN) && (occ < 2'(FIFO_DEPTH));
   end

   // read address generator: holds unless a read issues, stops on the last address
   always_ff @(posedge r_clk) begin
      if (!rst_n) begin
         r_row  <= 8'd0;
         r_col  <= 8'd0;
`ifdef CHAR_SCAN_LINE_REPEAT_EN
         line_q <= 3'd0;
`endif
      end else if ((state == IDLE) && start) begin
         r_row  <= 8'd0;
         r_col  <= 8'd0;
`ifdef CHAR_SCAN_LINE_REPEAT_EN
         line_q <= 3'd0;
`endif
      end else if (issue && !at_last) begin
         if (at_eol) begin
            r_col <= 8'd0;
`ifdef CHAR_SCAN_LINE_REPEAT_EN
            if (line_q == 3'd7) begin
               line_q <= 3'd0;
               r_row  <= r_row + 8'd1;
            end else begin
               line_q <= line_q + 3'd1;
            end
`else
            r_row <= r_row + 8'd1;
`endif
         end else begin
            r_col <= r_col + 8'd1;
         end
      end
   end

   // tag of the address being read this cycle; data is filled in on capture
   always_comb begin
      issue_ent      = '0;
      issue_ent.row  = r_row;
      issue_ent.col  = r_col;
      issue_ent.eol  = at_eol;
      issue_ent.eof  = at_last;
`ifdef CHAR_SCAN_LINE_REPEAT_EN
      issue_ent.line = line_q;
`endif
      push_ent       = tag_q;
      push_ent.data  = a_out;
   end

   // in-flight flag and tag: the buffer returns data one cycle after the address
   always_ff @(posedge r_clk) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         tag_q    <= '0;
      end else begin
         inflight <= issue;
         if (issue) tag_q <= issue_ent;
      end
   end

   // 2-entry first-word-fall-through skid FIFO; slot0 is the head
   always_ff @(posedge r_clk) begin
      if (!rst_n) begin
         count <= 2'd0;
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) slot0 <= push_ent;
               else               slot1 <= push_ent;
               count <= count + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - 2'd1;
            end
            2'b11: slot0 <= push_ent;
            default: ;
         endcase
      end
   end

   assign ch_valid = (count != 2'd0);
   assign ch_data  = slot0.data;
   assign ch_row   = slot0.row;
   assign ch_col   = slot0.col;
   assign ch_eol   = slot0.eol;
   assign ch_eof   = slot0.eof;
`ifdef CHAR_SCAN_LINE_REPEAT_EN
   assign ch_line  = slot0.line;
`endif

endmodule

// File: tb/tb_char_scan.sv
// Bench for char_scan: scoreboard of expected characters, monitor compares each stream handshake.
module tb_char_scan;
   localparam int COLS = 160;
   localparam int ROWS = 64;
`ifdef CHAR_SCAN_LINE_REPEAT_EN
   localparam int LINES    = 8;
   localparam int RST_ROW  = 2;
   localparam int WRAP_ROW = 5;
`else
   localparam int LINES    = 1;
   localparam int RST_ROW  = 20;
   localparam int WRAP_ROW = 6;
`endif
   localparam int FRAME = COLS * ROWS * LINES;

   logic       r_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       ch_ready = 1'b1;
   logic [7:0] a_out = 8'd0;
   logic       busy, frame_done, ch_eol, ch_eof, ch_valid;
   logic [7:0] r_row, r_col, ch_data, ch_row, ch_col;
   logic [2:0] mon_line;
`ifdef CHAR_SCAN_LINE_REPEAT_EN
   logic [2:0] ch_line;
   assign mon_line = ch_line;
`else
   assign mon_line = 3'd0;
`endif

   char_scan dut (
      .r_clk(r_clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
      .r_row(r_row), .r_col(r_col), .a_out(a_out),
      .ch_data(ch_data), .ch_row(ch_row), .ch_col(ch_col), .ch_eol(ch_eol), .ch_eof(ch_eof),
      .ch_valid(ch_valid),
`ifdef CHAR_SCAN_LINE_REPEAT_EN
      .ch_line(ch_line),
`endif
      .ch_ready(ch_ready)
   );

   always #5 r_clk = ~r_clk;

   // character buffer model with registered read port
   logic [7:0] mem [ROWS][COLS];
   always @(posedge r_clk) a_out <= mem[r_row][r_col];

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] r;
      logic [7:0] c;
      logic [2:0] ln;
      logic       eol;
      logic       eof;
   } exp_t;
   exp_t q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int fd_cnt = 0, fd_cyc = 0, first_v = -1, s_cyc = 0;
   int eol_cnt = 0, eof_cnt = 0, xfer_cnt = 0;
   logic prev_stall = 1'b0;
   logic [29:0] held;
   logic [7:0] p_r = 8'd0, p_c = 8'd0;
   logic wrap_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge r_clk) cyc <= cyc + 1;

   // monitor: pop-and-compare on handshake, hold check during stalls, event bookkeeping
   always @(negedge r_clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("stall_hold", {2'b0, ch_data, ch_row, ch_col, mon_line, ch_valid, ch_eol, ch_eof},
                {2'b0, held});
         if (ch_valid && first_v < 0) first_v = cyc;
         if (ch_valid && ch_ready) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_xfer: got row %0d col %0d with nothing expected", ch_row, ch_col);
            end else begin
               e = q.pop_front();
               chk("xfer", {3'b0, ch_data, ch_row, ch_col, mon_line, ch_eol, ch_eof},
                   {3'b0, e.d, e.r, e.c, e.ln, e.eol, e.eof});
               xfer_cnt++;
               if (ch_eol) eol_cnt++;
               if (ch_eof) eof_cnt++;
            end
         end
         prev_stall = ch_valid && !ch_ready;
         held = {ch_data, ch_row, ch_col, mon_line, 1'b1, ch_eol, ch_eof};
         if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
         end
         if (!wrap_done && p_r == 8'd5 && p_c == 8'(COLS - 1) && (r_row != p_r || r_col != p_c)) begin
            chk("row_wrap_addr", {r_row, r_col}, {8'(WRAP_ROW), 8'd0});
            wrap_done = 1'b1;
         end
      end
      p_r = r_row;
      p_c = r_col;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge r_clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      q.delete();
   endtask

   task automatic do_start();
      first_v = -1;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      s_cyc = cyc;
   endtask

   task automatic push_frame();
      for (int r = 0; r < ROWS; r++)
         for (int l = 0; l < LINES; l++)
            for (int c = 0; c < COLS; c++)
               q.push_back({mem[r][c], 8'(r), 8'(c), 3'(l), (c == COLS - 1),
                            (r == ROWS - 1 && c == COLS - 1 && l == LINES - 1)});
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      int fd0 = fd_cnt;
      while (fd_cnt == fd0 && n < limit) begin
         tick(1);
         n++;
      end
      chk("frame_done_seen", (fd_cnt != fd0), 1);
   endtask

   initial begin
      int n;
      int x0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            mem[r][c] = 8'(r + c);

      // reset state
      tick(2);
      rst_n = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_addr", {r_row, r_col}, 0);
      chk("rst_valid", ch_valid, 0);
      chk("rst_ch", {ch_data, ch_row, ch_col, ch_eol, ch_eof}, 0);

      // full frame at full rate, with a start pulse that must be ignored mid-scan
      ch_ready = 1'b1;
      eol_cnt = 0;
      eof_cnt = 0;
      push_frame();
      do_start();
      tick(3000);
      chk("busy_mid_frame", busy, 1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_done(FRAME + 100);
      chk("frame_len", fd_cyc - s_cyc, FRAME + 2);
      chk("first_valid_lat", first_v - s_cyc, 2);
      chk("eol_count", eol_cnt, ROWS * LINES);
      chk("eof_count", eof_cnt, 1);
      chk("queue_empty", q.size(), 0);
      chk("row_wrap_seen", wrap_done, 1);
      tick(1);
      chk("idle_busy", busy, 0);

      // stalled from start: two entries buffered, address stops at column 2
      ch_ready = 1'b0;
      push_frame();
      do_start();
      tick(8);
      chk("stall_addr", {r_row, r_col}, {8'd0, 8'd2});
      chk("stall_valid", ch_valid, 1);
      chk("stall_head", {ch_data, ch_row, ch_col}, {mem[0][0], 8'd0, 8'd0});
      tick(5);
      chk("stall_addr_hold", {r_row, r_col}, {8'd0, 8'd2});
      ch_ready = 1'b1;
      tick(1);
      chk("resume_addr", {r_row, r_col}, {8'd0, 8'd3});
      x0 = xfer_cnt;
      tick(20);
      chk("resume_xfers", xfer_cnt - x0, 20);
      do_reset();

      // random backpressure around 30% ready duty
      push_frame();
      x0 = xfer_cnt;
      do_start();
      repeat (3000) begin
         ch_ready = ($urandom_range(0, 9) < 3);
         tick(1);
      end
      ch_ready = 1'b1;
      chk("rand_progress", (xfer_cnt - x0) > 500, 1);
      do_reset();

      // reset mid-frame, then a fresh scan from (0,0)
      push_frame();
      do_start();
      n = 0;
      while (!(r_row == 8'(RST_ROW) && r_col == 8'd77) && n < FRAME) begin
         tick(1);
         n++;
      end
      chk("reached_rst_point", {r_row, r_col}, {8'(RST_ROW), 8'd77});
      do_reset();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", ch_valid, 0);
      chk("mid_rst_addr", {r_row, r_col}, 0);
      chk("mid_rst_ch", {ch_data, ch_row, ch_col, ch_eol, ch_eof}, 0);
      chk("mid_rst_fd", frame_done, 0);
      tick(3);
      chk("no_stale_emit", ch_valid, 0);
      push_frame();
      x0 = xfer_cnt;
      do_start();
      tick(300);
      chk("rescan_xfers", xfer_cnt - x0, 298);
      do_reset();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
